pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//   Parametrised elastic pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries a control bundle and a data payload with a valid/ready handshake, a 2-entry skid buffer and a flush.
//   Sustains 1 beat/cycle under backpressure.
//   The ready path is registered, so the stage breaks timing between the hazard unit and upstream stages.
// PARAMETERS
//   CTRL_W  8   width of control bundle (regWrite, memtoReg, memWrite, sb, lh, ld, halt, ...)
//   DATA_W  128 width of data payload (PC, operands, immediate, register indices)
//   CNT_W   32  width of performance counters (only with PIPE_STAGE_PERF_EN)
// PORTS
//   clock        in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high reset
//   flush        in   1       discard all held beats and any beat accepted this cycle
//   valid_in     in   1       upstream beat valid
//   ready_out    out  1       stage can accept; registered, equals !skid_valid
//   ctrl_in      in   CTRL_W  upstream control bundle
//   data_in      in   DATA_W  upstream data payload
//   valid_out    out  1       main slot holds a valid beat
//   ready_in     in   1       downstream accepts (hazard stall = ready_in low)
//   ctrl_out     out  CTRL_W  control bundle of main slot; all-zero whenever valid_out=0
//   data_out     out  DATA_W  data payload of main slot
//   stall_cnt    out  CNT_W   [PIPE_STAGE_PERF_EN] cycles with valid_out & !ready_in
//   bubble_cnt   out  CNT_W   [PIPE_STAGE_PERF_EN] cycles with valid_out=0
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - Reset: state EMPTY; valid_out=0, ready_out=1, ctrl_out=0, data_out=0; skid contents=0; counters=0.
//   - Accept handshake: acc = valid_in & ready_out. Release handshake: rel = valid_out & ready_in.
//   - Latency: an accepted beat appears on the outputs 1 cycle later when the stage is EMPTY, or ONE with rel.
//   - States: EMPTY (no beat), ONE (main valid), TWO (main+skid valid, ready_out=0).
//     EMPTY: acc -> ONE, main<=in.
//     ONE:   acc&rel -> ONE, main<=in.  acc&!rel -> TWO, skid<=in.  !acc&rel -> EMPTY.  else hold.
//     TWO:   rel -> ONE, main<=skid, skid cleared.  !rel -> hold. valid_in is ignored because ready_out=0.
//   - Ordering: strictly FIFO; the skid beat always precedes any later beat.
//   - Flush overrides everything: next state EMPTY; main and skid ctrl zeroed; data_out keeps its value.
//     Any beat accepted in the flush cycle is dropped. A release in the flush cycle still counts as delivered.
//   - Bubble safety: ctrl_out is driven to 0 on every transition into EMPTY, so regWrite/memWrite are never asserted by a bubble.
//   - Reset mid-transfer: all beats are lost, outputs zero immediately (asynchronous).
//   - No combinational path from ready_in or valid_in to ready_out.
// CONFIGURATION
//   PIPE_STAGE_PERF_EN defined:
//     stall_cnt and bubble_cnt ports exist.
//     Both counters saturate at 2^CNT_W-1, are cleared only by reset and are unaffected by flush.
//   PIPE_STAGE_PERF_EN undefined: counter ports and logic are absent. The stage is otherwise identical.
// STRUCTURE
//   Package pipe_pkg:
//     state typedef {EMPTY, ONE, TWO};
//     default width constants (CTRL_W_DEF=8, DATA_W_DEF=128);
//     control-bundle bit-index constants shared by the decoder and every stage.
//   Sub-module pipe_slot:
//     one register slot {valid, ctrl, data} with load and clear inputs;
//     instantiated twice (main, skid).
//   Top-level holds the state register, handshake logic and optional counters.
// TESTING
//   1. Reset during TWO: reset=1 mid-cycle -> valid_out=0, ready_out=1, ctrl_out=0 without waiting for a clock edge.
//   2. Streaming: ready_in=1, beats ctrl 0x01..0x10 on consecutive cycles.
//      Required: identical sequence out, 1-cycle latency, no gaps, ready_out always 1.
//   3. Backpressure: ready_in=0 after beat A is in main, upstream presents B then C.
//      Required: B goes to skid; ready_out=0 next cycle; C is held upstream.
//      After ready_in=1: order is A, B, C with no loss or duplication.
//   4. Flush in TWO with valid_in=1:
//      Required: next cycle valid_out=0, ctrl_out=0x00, ready_out=1.
//      The beat presented during flush never appears.
//   5. Perf: with PIPE_STAGE_PERF_EN and CNT_W=4, hold a stall for 20 cycles.
//      Required: stall_cnt=15 (saturated); a flush leaves it at 15.
//      Without the macro the bench compiles with no counter ports.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
//   pipe_state_e   : occupancy state of a stage (EMPTY, ONE, TWO)
//   CTRL_W_DEF     : default control-bundle width
//   DATA_W_DEF     : default data-payload width
//   CTRL_*         : bit positions inside the control bundle, shared by the
//                    decoder and every stage that inspects control bits.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no beat held
    ONE   = 2'd1,  // main slot valid
    TWO   = 2'd2   // main and skid slots valid, ready_out low
  } pipe_state_e;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 128;

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_SB = 3;
  localparam int CTRL_LH = 4;
  localparam int CTRL_LD = 5;
  localparam int CTRL_HALT = 6;

endpackage

// File: rtl/pipe_slot.sv
// One register slot of an elastic stage: {valid, ctrl, data}.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load         : capture ctrl_d/data_d and mark the slot valid
//   clear        : drop the held beat; valid and ctrl go to zero, data is kept
//                  (clear wins over load)
//   ctrl_d/data_d: incoming beat
//   valid/ctrl/data : slot contents
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // ctrl is zeroed on clear so an empty slot can never present live control
  // bits; data is left alone because nothing qualifies on it without valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrl_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with a 2-entry skid buffer and flush.
// Sustains one beat per cycle; ready_out comes straight from a flop so the
// downstream stall never reaches upstream combinationally.
//
// Handshake: a beat moves on a channel in a cycle where valid and ready are
// both high at the rising edge (acc = valid_in & ready_out upstream,
// rel = valid_out & ready_in downstream). A producer holds valid and its
// payload stable until the beat is taken; valid never depends on ready.
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds the CNT_W parameter and the
// saturating stall_cnt / bubble_cnt counters.
//
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   flush         : discard held beats and any beat accepted this cycle
//   valid_in, ready_out, ctrl_in, data_in   : upstream channel
//   valid_out, ready_in, ctrl_out, data_out : downstream channel
//   stall_cnt     : cycles with valid_out & !ready_in (PIPE_STAGE_PERF_EN)
//   bubble_cnt    : cycles with valid_out = 0 (PIPE_STAGE_PERF_EN)
//   state_dbg     : current occupancy state
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output pipe_state_e       state_dbg
);

  pipe_state_e state, state_next;

  logic              acc, rel;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  // Both terms are flop outputs, so ready_out has no path from any input.
  assign ready_out = !skid_valid;
  assign valid_out = main_valid;
  assign ctrl_out  = main_ctrl;
  assign data_out  = main_data;
  assign state_dbg = state;

  assign acc = valid_in && ready_out;
  assign rel = valid_out && ready_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;

    if (flush) begin
      // A release in this cycle has already happened on the wire; anything
      // accepted alongside it is simply never loaded.
      state_next = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_next = ONE;
            main_load  = 1'b1;
          end
        end
        ONE: begin
          if (acc && rel) begin
            main_load = 1'b1;
          end else if (acc) begin
            state_next = TWO;
            skid_load  = 1'b1;
          end else if (rel) begin
            state_next = EMPTY;
            main_clear = 1'b1;
          end
        end
        TWO: begin
          // ready_out is low here, so valid_in cannot be accepted.
          if (rel) begin
            state_next     = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // The skid beat is older than anything upstream, so it always refills main
  // first; this keeps the stage strictly in order.
  assign main_ctrl_d = main_from_skid ? skid_ctrl : ctrl_in;
  assign main_data_d = main_from_skid ? skid_data : data_in;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clock  (clock),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clock  (clock),
    .reset  (reset),
    .load   (skid_load),
    .clear  (skid_clear),
    .ctrl_d (ctrl_in),
    .data_d (data_in),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; only reset clears them, flush has no effect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (valid_out && !ready_in && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (!valid_out && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
